// File: rtl/frame_buffer_writer.sv
// Write side of the double-buffered frame store: turns accepted (x, y, color) pixels into
// one-cycle M10K write strobes on the back bank and swaps banks on vblank once a frame is full.
module frame_buffer_writer #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [9:0]         in_x,
  input  logic [9:0]         in_y,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               frame_start,
  output logic               wr_en,
  output logic               wr_bank,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               front_bank,
  output logic [15:0]        frame_count,
  output logic               oob_err
);

  typedef enum logic {
    S_FILL,
    S_WAIT_SWAP
  } state_t;

  localparam logic [10:0]     LP_H_LIM     = 11'(H_RES);
  localparam logic [10:0]     LP_V_LIM     = 11'(V_RES);
  localparam logic [ADDR_W:0] LP_FRAME_PIX = (ADDR_W+1)'(H_RES * V_RES);
  localparam logic [ADDR_W:0] LP_CNT_ONE   = (ADDR_W+1)'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_W:0]      r_pix_cnt;
  logic                 r_front_bank;
  logic [15:0]          r_frame_cnt;
  logic                 r_oob_err;
  logic                 r_vld_p1;
  logic [ADDR_W-1:0]    r_addr_p1;
  logic [COLOR_W-1:0]   r_data_p1;

  logic                 w_in_ready;
  logic                 w_fill;
  logic                 w_accept;
  logic                 w_in_range;
  logic                 w_wr_go;
  logic                 w_oob_go;
  logic [ADDR_W:0]      w_cnt_inc;
  logic                 w_frame_done;
  logic                 w_swap;
  logic [ADDR_W-1:0]    w_addr;

  // Row base y*H_RES as a sum of shifted copies of y, one per set bit of H_RES.
  function automatic logic [ADDR_W-1:0] f_row_base(input logic [9:0] y);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < 32; b++) begin
      if (((H_RES >> b) & 1) != 0) begin
        acc = acc + (ADDR_W'(y) << b);
      end
    end
    return acc;
  endfunction

  // Accept path is built from the state directly so in_ready never feeds back into itself.
  assign w_fill       = (r_state == S_FILL) && !reset;
  assign w_accept     = in_valid && w_fill;
  assign w_in_range   = ({1'b0, in_x} < LP_H_LIM) && ({1'b0, in_y} < LP_V_LIM);
  assign w_wr_go      = w_accept && w_in_range;
  assign w_oob_go     = w_accept && !w_in_range;
  assign w_cnt_inc    = r_pix_cnt + LP_CNT_ONE;
  assign w_frame_done = w_wr_go && (w_cnt_inc == LP_FRAME_PIX);
  assign w_swap       = (r_state == S_WAIT_SWAP) && frame_start;
  assign w_addr       = f_row_base(in_y) + ADDR_W'(in_x);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_FILL: begin
        w_in_ready = !reset;
        if (w_frame_done) begin
          w_state_nxt = S_WAIT_SWAP;
        end
      end
      S_WAIT_SWAP: begin
        if (frame_start) begin
          w_state_nxt = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix_cnt    <= '0;
      r_front_bank <= 1'b0;
      r_frame_cnt  <= '0;
      r_oob_err    <= 1'b0;
    end else begin
      if (w_swap) begin
        r_pix_cnt    <= '0;
        r_front_bank <= ~r_front_bank;
        r_frame_cnt  <= r_frame_cnt + 16'd1;
      end else if (w_wr_go) begin
        r_pix_cnt <= w_cnt_inc;
      end
      if (w_oob_go) begin
        r_oob_err <= 1'b1;
      end
    end
  end

  // ---- stage p1: registered write strobe, address and data ----
  // Reset clears the data fields too, so a write pending at reset never leaks out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_addr_p1 <= '0;
      r_data_p1 <= '0;
    end else begin
      r_vld_p1 <= w_wr_go;
      if (w_wr_go) begin
        r_addr_p1 <= w_addr;
        r_data_p1 <= in_color;
      end
    end
  end

  // The last write of a frame precedes the earliest swap, so the live back bank is always correct.
  assign in_ready    = w_in_ready;
  assign wr_en       = r_vld_p1;
  assign wr_addr     = r_addr_p1;
  assign wr_data     = r_data_p1;
  assign wr_bank     = ~r_front_bank;
  assign front_bank  = r_front_bank;
  assign frame_count = r_frame_cnt;
  assign oob_err     = r_oob_err;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench: a 640x480 instance for addressing/range checks and a 4x2 instance for
// frame fill, vblank swap and mid-frame reset behaviour.
module tb_frame_buffer_writer;

  logic        clk;
  int          n_pass;
  int          n_total;

  logic        a_reset, a_in_valid, a_in_ready, a_frame_start;
  logic [9:0]  a_in_x, a_in_y, a_in_color;
  logic        a_wr_en, a_wr_bank, a_front_bank, a_oob_err;
  logic [18:0] a_wr_addr;
  logic [9:0]  a_wr_data;
  logic [15:0] a_frame_count;

  logic        b_reset, b_in_valid, b_in_ready, b_frame_start;
  logic [9:0]  b_in_x, b_in_y, b_in_color;
  logic        b_wr_en, b_wr_bank, b_front_bank, b_oob_err;
  logic [2:0]  b_wr_addr;
  logic [9:0]  b_wr_data;
  logic [15:0] b_frame_count;

  frame_buffer_writer u_dut_a (
    .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_x(a_in_x), .in_y(a_in_y), .in_color(a_in_color), .frame_start(a_frame_start),
    .wr_en(a_wr_en), .wr_bank(a_wr_bank), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .front_bank(a_front_bank), .frame_count(a_frame_count), .oob_err(a_oob_err)
  );

  frame_buffer_writer #(.H_RES(4), .V_RES(2), .ADDR_W(3), .COLOR_W(10)) u_dut_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_x(b_in_x), .in_y(b_in_y), .in_color(b_in_color), .frame_start(b_frame_start),
    .wr_en(b_wr_en), .wr_bank(b_wr_bank), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .front_bank(b_front_bank), .frame_count(b_frame_count), .oob_err(b_oob_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;

    // Reset held 3 cycles with valid and vblank active on both instances
    a_reset = 1; a_in_valid = 1; a_frame_start = 1; a_in_x = 0; a_in_y = 0; a_in_color = 0;
    b_reset = 1; b_in_valid = 1; b_frame_start = 1; b_in_x = 0; b_in_y = 0; b_in_color = 0;
    tick(); tick(); tick();
    chk("rst_in_ready",    32'(a_in_ready), 32'd0);
    chk("rst_wr_en",       32'(a_wr_en), 32'd0);
    chk("rst_front_bank",  32'(a_front_bank), 32'd0);
    chk("rst_wr_bank",     32'(a_wr_bank), 32'd1);
    chk("rst_frame_count", 32'(a_frame_count), 32'd0);
    chk("rst_oob_err",     32'(a_oob_err), 32'd0);
    chk("rst_b_in_ready",  32'(b_in_ready), 32'd0);
    a_reset = 0; a_in_valid = 0; a_frame_start = 0;
    b_reset = 0; b_in_valid = 0; b_frame_start = 0;
    tick();
    chk("idle_wr_en", 32'(a_wr_en), 32'd0);

    // Single pixel on the 640x480 instance: 2*640+3 = 1283
    a_in_valid = 1; a_in_x = 10'd3; a_in_y = 10'd2; a_in_color = 10'h2A5;
    chk("single_in_ready", 32'(a_in_ready), 32'd1);
    tick();
    a_in_valid = 0;
    chk("single_wr_en",   32'(a_wr_en), 32'd1);
    chk("single_wr_addr", 32'(a_wr_addr), 32'd1283);
    chk("single_wr_data", 32'(a_wr_data), 32'h2A5);
    chk("single_wr_bank", 32'(a_wr_bank), 32'd1);
    tick();
    chk("single_wr_en_drop", 32'(a_wr_en), 32'd0);
    chk("single_oob_clear",  32'(a_oob_err), 32'd0);

    // Bottom-right corner: 479*640+639 = 307199
    a_in_valid = 1; a_in_x = 10'd639; a_in_y = 10'd479; a_in_color = 10'h155;
    tick();
    a_in_valid = 0;
    chk("corner_wr_addr", 32'(a_wr_addr), 32'd307199);
    chk("corner_wr_data", 32'(a_wr_data), 32'h155);

    // Out-of-range x, then out-of-range y
    a_in_valid = 1; a_in_x = 10'd640; a_in_y = 10'd0;
    tick();
    a_in_valid = 0;
    chk("oob_x_wr_en",   32'(a_wr_en), 32'd0);
    chk("oob_x_oob_err", 32'(a_oob_err), 32'd1);
    chk("oob_in_ready",  32'(a_in_ready), 32'd1);
    a_in_valid = 1; a_in_x = 10'd0; a_in_y = 10'd480;
    tick();
    a_in_valid = 0;
    chk("oob_y_wr_en", 32'(a_wr_en), 32'd0);
    tick(); tick();
    chk("oob_sticky", 32'(a_oob_err), 32'd1);

    // 4x2 instance: an out-of-range pixel does not count toward the frame
    b_in_valid = 1; b_in_x = 10'd4; b_in_y = 10'd0;
    tick();
    chk("b_oob_wr_en",   32'(b_wr_en), 32'd0);
    chk("b_oob_oob_err", 32'(b_oob_err), 32'd1);

    // 8 back-to-back pixels; vblank pulsed in FILL and on the 8th-accept cycle
    for (int i = 0; i < 8; i++) begin
      b_in_valid = 1; b_in_x = 10'(i % 4); b_in_y = 10'(i / 4); b_in_color = 10'(256 + i);
      b_frame_start = (i == 2 || i == 7);
      tick();
      chk("fill_wr_en",    32'(b_wr_en), 32'd1);
      chk("fill_wr_addr",  32'(b_wr_addr), 32'(i));
      chk("fill_wr_data",  32'(b_wr_data), 32'(256 + i));
      chk("fill_wr_bank",  32'(b_wr_bank), 32'd1);
      chk("fill_in_ready", 32'(b_in_ready), (i < 7) ? 32'd1 : 32'd0);
    end
    b_frame_start = 0; b_in_x = 0; b_in_y = 0; b_in_color = 10'h3FF;
    chk("coincident_no_swap", 32'(b_front_bank), 32'd0);
    tick();
    chk("stall_wr_en",       32'(b_wr_en), 32'd0);
    chk("stall_in_ready",    32'(b_in_ready), 32'd0);
    chk("stall_front_bank",  32'(b_front_bank), 32'd0);
    chk("stall_frame_count", 32'(b_frame_count), 32'd0);

    // vblank in WAIT_SWAP swaps banks
    b_frame_start = 1;
    tick();
    b_frame_start = 0;
    chk("swap_front_bank",  32'(b_front_bank), 32'd1);
    chk("swap_frame_count", 32'(b_frame_count), 32'd1);
    chk("swap_in_ready",    32'(b_in_ready), 32'd1);
    chk("swap_wr_en",       32'(b_wr_en), 32'd0);
    tick();
    chk("post_swap_wr_en",   32'(b_wr_en), 32'd1);
    chk("post_swap_wr_bank", 32'(b_wr_bank), 32'd0);
    chk("post_swap_wr_addr", 32'(b_wr_addr), 32'd0);
    chk("post_swap_wr_data", 32'(b_wr_data), 32'h3FF);

    // Reset after 5 of 8 pixels with an accept in the preceding cycle
    for (int i = 1; i < 5; i++) begin
      b_in_x = 10'(i % 4); b_in_y = 10'(i / 4); b_in_color = 10'(i);
      tick();
    end
    chk("pre_rst_wr_addr", 32'(b_wr_addr), 32'd4);
    b_reset = 1;
    tick();
    chk("midrst_wr_en",       32'(b_wr_en), 32'd0);
    chk("midrst_in_ready",    32'(b_in_ready), 32'd0);
    chk("midrst_front_bank",  32'(b_front_bank), 32'd0);
    chk("midrst_frame_count", 32'(b_frame_count), 32'd0);
    chk("midrst_oob_err",     32'(b_oob_err), 32'd0);
    chk("midrst_wr_addr",     32'(b_wr_addr), 32'd0);
    b_reset = 0; b_in_valid = 0;
    tick();
    chk("postrst_wr_en", 32'(b_wr_en), 32'd0);
    for (int i = 0; i < 8; i++) begin
      b_in_valid = 1; b_in_x = 10'(i % 4); b_in_y = 10'(i / 4); b_in_color = 10'(i);
      tick();
      chk("refill_wr_addr",  32'(b_wr_addr), 32'(i));
      chk("refill_wr_bank",  32'(b_wr_bank), 32'd1);
      chk("refill_in_ready", 32'(b_in_ready), (i < 7) ? 32'd1 : 32'd0);
    end
    b_in_valid = 0;
    chk("refill_front_bank", 32'(b_front_bank), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
